// File: rtl/serial_link_pkg.sv
// Constants shared by both ends of the 5-bit serial link.
// The FSM state encodings and the line levels are the same ones the transmitter uses.
package serial_link_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/serial_receiver5_if.sv
// Line-side and consumer-side signals of the serial receiver.
// The master is the line/consumer side, and the slave is the receiver.
interface serial_receiver5_if #(
    parameter int unsigned WIDTH = 5
);
    logic             serial_input;
    logic             bit_enable;
    logic             data_ack;
    logic [WIDTH-1:0] parallel_data;
    logic             data_valid;
    logic             framing_error;
    logic             overrun_error;
    logic             busy;

    modport master (
        output serial_input, bit_enable, data_ack,
        input  parallel_data, data_valid, framing_error, overrun_error, busy
    );

    modport slave (
        input  serial_input, bit_enable, data_ack,
        output parallel_data, data_valid, framing_error, overrun_error, busy
    );
endinterface

// File: rtl/shiftregister_sipo_right.sv
// Serial-in, parallel-out right shifter: each new bit enters the MSB.
// After WIDTH shifts, bit0 holds the first bit that was received.
module shiftregister_sipo_right #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clockpulse,
    input  logic             clear_,
    input  logic             shift_enable,
    input  logic             serial_input,
    output logic [WIDTH-1:0] parallel_out
);
    always_ff @(posedge clockpulse) begin
        if (!clear_)
            parallel_out <= '0;
        else if (shift_enable)
            parallel_out <= {serial_input, parallel_out[WIDTH-1:1]};
    end
endmodule

// File: rtl/serial_receiver5.sv
// Receive end of the serial link: start/data/stop framing FSM, bit counter,
// output holding register, and one-cycle framing/overrun pulses.
module serial_receiver5
    import serial_link_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input logic               clockpulse,
    input logic               clear_,
    serial_receiver5_if.slave link
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CW-1:0]    bit_count;
    logic [WIDTH-1:0] shift_word;
    logic [WIDTH-1:0] hold_word;
    logic             valid_q;
    logic             framing_q;
    logic             overrun_q;
    logic             shift_en;

    assign shift_en = link.bit_enable && (state == ST_DATA);

    shiftregister_sipo_right #(.WIDTH(WIDTH)) u_shift (
        .clockpulse   (clockpulse),
        .clear_       (clear_),
        .shift_enable (shift_en),
        .serial_input (link.serial_input),
        .parallel_out (shift_word)
    );

    always_ff @(posedge clockpulse) begin
        if (!clear_) begin
            state     <= ST_IDLE;
            bit_count <= '0;
            hold_word <= '0;
            valid_q   <= 1'b0;
            framing_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            framing_q <= 1'b0;
            overrun_q <= 1'b0;
            // The ack clear comes first so that a load on the same edge can override it.
            if (link.data_ack && valid_q)
                valid_q <= 1'b0;
            if (link.bit_enable) begin
                case (state)
                    ST_IDLE: begin
                        if (link.serial_input == START_BIT) begin
                            state     <= ST_DATA;
                            bit_count <= '0;
                        end
                    end
                    ST_DATA: begin
                        bit_count <= bit_count + 1'b1;
                        if (bit_count == CW'(WIDTH - 1))
                            state <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (link.serial_input == STOP_BIT) begin
                            if (!valid_q || link.data_ack) begin
                                hold_word <= shift_word;
                                valid_q   <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            framing_q <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign link.parallel_data = hold_word;
    assign link.data_valid    = valid_q;
    assign link.framing_error = framing_q;
    assign link.overrun_error = overrun_q;
    assign link.busy          = (state != ST_IDLE);
endmodule

// File: tb/tb_serial_receiver5.sv
// Testbench for serial_receiver5: directed frames plus randomized frames, checked
// against a frame-level model of the consumer-visible word and valid flag.
module tb_serial_receiver5;
    localparam int unsigned W = 5;

    logic clk = 1'b0;
    logic clear_;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] exp_data;
    logic         exp_valid;

    serial_receiver5_if #(.WIDTH(W)) link ();

    serial_receiver5 #(.WIDTH(W)) dut (
        .clockpulse (clk),
        .clear_     (clear_),
        .link       (link.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gaps(input int unsigned n);
        for (int unsigned g = 0; g < n; g++) begin
            link.bit_enable   = 1'b0;
            link.serial_input = $urandom_range(1, 0);
            tick();
            check("gap_busy", {31'd0, link.busy}, 32'd1);
            check("gap_no_pulse", {30'd0, link.framing_error, link.overrun_error}, 32'd0);
        end
    endtask

    // Send a frame, then check the outcome using the model.
    // The word is sent LSB first, and the stop bit is given by stop_bit.
    task automatic send_frame(input logic [W-1:0] word, input logic stop_bit,
                              input int unsigned gaps, input logic ack_on_stop);
        logic load;
        logic good;
        link.bit_enable   = 1'b1;
        link.serial_input = 1'b0;
        link.data_ack     = 1'b0;
        tick();
        check("start_busy", {31'd0, link.busy}, 32'd1);
        for (int unsigned i = 0; i < W; i++) begin
            idle_gaps(gaps);
            link.bit_enable   = 1'b1;
            link.serial_input = word[i];
            tick();
            check("data_valid_hold", {31'd0, link.data_valid}, {31'd0, exp_valid});
        end
        idle_gaps(gaps);
        link.bit_enable   = 1'b1;
        link.serial_input = stop_bit;
        link.data_ack     = ack_on_stop;
        tick();
        good = stop_bit;
        load = good && (!exp_valid || ack_on_stop);
        if (load) begin
            exp_data  = word;
            exp_valid = 1'b1;
        end else if (ack_on_stop) begin
            exp_valid = 1'b0;
        end
        check("stop_data", {27'd0, link.parallel_data}, {27'd0, exp_data});
        check("stop_valid", {31'd0, link.data_valid}, {31'd0, exp_valid});
        check("stop_framing", {31'd0, link.framing_error}, {31'd0, !good});
        check("stop_overrun", {31'd0, link.overrun_error}, {31'd0, good && !load});
        check("stop_busy", {31'd0, link.busy}, 32'd0);
        // The pulses must fall even if the line is gated off on the next cycle.
        link.serial_input = 1'b1;
        link.data_ack     = 1'b0;
        link.bit_enable   = $urandom_range(1, 0);
        tick();
        check("pulse_end", {30'd0, link.framing_error, link.overrun_error}, 32'd0);
        check("post_busy", {31'd0, link.busy}, 32'd0);
    endtask

    task automatic ack_cycle();
        link.bit_enable   = 1'b1;
        link.serial_input = 1'b1;
        link.data_ack     = 1'b1;
        tick();
        exp_valid = 1'b0;
        link.data_ack = 1'b0;
        check("ack_valid", {31'd0, link.data_valid}, 32'd0);
        check("ack_data", {27'd0, link.parallel_data}, {27'd0, exp_data});
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {24'd0, link.parallel_data, link.data_valid, link.framing_error,
                    link.overrun_error}, 32'd0);
        check({tag, "_busy"}, {31'd0, link.busy}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] rw;
        clear_            = 1'b0;
        link.serial_input = 1'b1;
        link.bit_enable   = 1'b1;
        link.data_ack     = 1'b0;
        exp_data          = '0;
        exp_valid         = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        clear_ = 1'b1;
        tick();
        tick();
        check_all_zero("idle");

        // Test 1: basic frame, which is 5'b01101 on the wire as 1,0,1,1,0.
        send_frame(5'b01101, 1'b1, 0, 1'b0);
        check("t1_word", {27'd0, link.parallel_data}, 32'h0d);
        ack_cycle();
        // Test 2: bad stop bit.
        send_frame(5'b01101, 1'b0, 0, 1'b0);
        // Test 3: overrun, then load on an ack at the stop edge.
        send_frame(5'b10011, 1'b1, 0, 1'b0);
        send_frame(5'b00100, 1'b1, 0, 1'b0);
        check("t3_kept", {27'd0, link.parallel_data}, 32'h13);
        send_frame(5'b00100, 1'b1, 0, 1'b1);
        check("t3_loaded", {27'd0, link.parallel_data}, 32'h04);
        ack_cycle();
        // Test 4: gated frame.
        send_frame(5'b11111, 1'b1, 3, 1'b0);
        // Test 5: reset mid-frame while a word is valid.
        link.bit_enable   = 1'b1;
        link.serial_input = 1'b0;
        tick();
        for (int unsigned i = 0; i < 3; i++) begin
            link.serial_input = 1'b0;
            tick();
        end
        clear_ = 1'b0;
        tick();
        check_all_zero("t5_reset");
        tick();
        check_all_zero("t5_reset2");
        clear_    = 1'b1;
        exp_data  = '0;
        exp_valid = 1'b0;
        link.serial_input = 1'b1;
        tick();
        check_all_zero("t5_after");
        send_frame(5'b01010, 1'b1, 0, 1'b0);
        // Test 6: ack and a redundant ack.
        ack_cycle();
        send_frame(5'b00001, 1'b1, 0, 1'b0);
        ack_cycle();
        ack_cycle();

        // Randomized frames.
        for (int unsigned n = 0; n < 40; n++) begin
            rw = W'($urandom);
            send_frame(rw, ($urandom_range(4, 0) != 0), $urandom_range(2, 0),
                       $urandom_range(1, 0));
            if ($urandom_range(2, 0) == 0)
                ack_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
